// File: rtl/hdlc_crc_pkg.sv
// rtl/hdlc_crc_pkg.sv - shared constants and FSM state type for the HDLC CRC-16 engine
//
// Purpose: reflected CRC-16/CCITT polynomial, default LFSR init/final-XOR/residue
//          values and the frame FSM state encoding.
// Ports:   none (package).
package hdlc_crc_pkg;

    localparam logic [15:0] CRC_POLY_REFL          = 16'h8408;
    localparam logic [15:0] CRC_INIT_DEFAULT       = 16'hFFFF;
    localparam logic [15:0] CRC_FINAL_XOR_DEFAULT  = 16'h0000;
    localparam logic [15:0] CRC_RESIDUE_DEFAULT    = 16'hF0B8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY   = 2'd1,
        RESULT = 2'd2
    } state_t;

endpackage

// File: rtl/hdlc_crc_engine_if.sv
// rtl/hdlc_crc_engine_if.sv - frame beat stream and CRC result handshake bundle
//
// Purpose: groups the beat input stream (valid/ready/data/keep/last/abort) and the
//          result handshake (crc_valid/crc_ready/crc_out/crc_ok/byte_cnt).
// Modports:
//   master - frame source / result consumer (drives beats and crc_ready)
//   slave  - CRC engine (drives s_ready and the result outputs)
interface hdlc_crc_engine_if #(
    parameter int DATA_W = 16
);
    localparam int NB = DATA_W / 8;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic [NB-1:0]     s_keep;
    logic              s_last;
    logic              s_abort;
    logic              crc_valid;
    logic              crc_ready;
    logic [15:0]       crc_out;
    logic              crc_ok;
    logic [15:0]       byte_cnt;

    modport master (
        output s_valid, s_data, s_keep, s_last, s_abort, crc_ready,
        input  s_ready, crc_valid, crc_out, crc_ok, byte_cnt
    );

    modport slave (
        input  s_valid, s_data, s_keep, s_last, s_abort, crc_ready,
        output s_ready, crc_valid, crc_out, crc_ok, byte_cnt
    );

endinterface

// File: rtl/hdlc_crc_byte_step.sv
// rtl/hdlc_crc_byte_step.sv - one-byte reflected CRC-16 update (combinational)
//
// Purpose: next register value after shifting one byte, LSB first, through the
//          right-shifting CRC-16/CCITT LFSR.
// Ports:
//   crc_in  in  16  current register
//   data    in  8   byte to absorb
//   crc_out out 16  register after the byte
module hdlc_crc_byte_step
    import hdlc_crc_pkg::*;
(
    input  logic [15:0] crc_in,
    input  logic [7:0]  data,
    output logic [15:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ {8'h00, data};
        for (int b = 0; b < 8; b++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY_REFL) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/hdlc_crc_engine.sv
// rtl/hdlc_crc_engine.sv - CRC-16/CCITT frame engine for the GBT-SCA HDLC path
//
// Purpose: absorbs a frame as DATA_W-bit beats (NB byte lanes, contiguous keep),
//          returns register ^ FINAL_XOR and the frame byte count through a result
//          handshake. s_abort discards the frame at any point.
// Config macro: HDLC_CRC_CHECK_EN - when defined, crc_ok reports register == RESIDUE
//          at frame end; otherwise crc_ok is tied 0.
// Ports:
//   clk    in  clock
//   rst_n  in  asynchronous active-low reset
//   bus    hdlc_crc_engine_if.slave (beat stream in, result out)
module hdlc_crc_engine
    import hdlc_crc_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter logic [15:0] INIT      = CRC_INIT_DEFAULT,
    parameter logic [15:0] FINAL_XOR = CRC_FINAL_XOR_DEFAULT,
    parameter logic [15:0] RESIDUE   = CRC_RESIDUE_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    hdlc_crc_engine_if.slave   bus
);

    localparam int NB = DATA_W / 8;

    state_t        state;
    logic [15:0]   crc_reg;
    logic [15:0]   byte_cnt_q;
    logic [15:0]   crc_out_q;
    logic          crc_valid_q;
    logic          s_ready_q;

    logic [NB-1:0] lane_en;
    logic [4:0]    lane_cnt;
    logic [16:0]   byte_sum;
    logic [15:0]   cnt_next;
    logic [15:0]   crc_next;
    logic [15:0]   chain    [0:NB];
    logic [15:0]   step_out [0:NB-1];
    logic          accept;
    logic          frame_done;

    // A lane is live only while every lower keep bit is also set, so a stray
    // keep bit above the first hole is ignored.
    always_comb begin
        logic run;
        run      = 1'b1;
        lane_en  = '0;
        lane_cnt = '0;
        for (int i = 0; i < NB; i++) begin
            run        = run & bus.s_keep[i];
            lane_en[i] = run;
            lane_cnt   = lane_cnt + 5'(run);
        end
    end

    assign chain[0] = crc_reg;

    for (genvar k = 0; k < NB; k++) begin : g_lane
        hdlc_crc_byte_step u_step (
            .crc_in  (chain[k]),
            .data    (bus.s_data[8*k +: 8]),
            .crc_out (step_out[k])
        );
        assign chain[k+1] = lane_en[k] ? step_out[k] : chain[k];
    end

    assign crc_next   = chain[NB];
    assign byte_sum   = {1'b0, byte_cnt_q} + 17'(lane_cnt);
    assign cnt_next   = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];

    // s_ready_q is only high in IDLE/BUSY, so accept never fires in RESULT.
    assign accept     = bus.s_valid & s_ready_q;
    assign frame_done = accept & bus.s_last & ~bus.s_abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            crc_reg     <= INIT;
            byte_cnt_q  <= '0;
            crc_out_q   <= '0;
            crc_valid_q <= 1'b0;
            s_ready_q   <= 1'b0;
        end else if (bus.s_abort) begin
            state       <= IDLE;
            crc_reg     <= INIT;
            byte_cnt_q  <= '0;
            crc_valid_q <= 1'b0;
            s_ready_q   <= 1'b1;
        end else begin
            case (state)
                IDLE, BUSY: begin
                    s_ready_q <= 1'b1;
                    if (accept) begin
                        crc_reg    <= crc_next;
                        byte_cnt_q <= cnt_next;
                        if (bus.s_last) begin
                            state       <= RESULT;
                            crc_out_q   <= crc_next ^ FINAL_XOR;
                            crc_valid_q <= 1'b1;
                            s_ready_q   <= 1'b0;
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                RESULT: begin
                    if (bus.crc_ready) begin
                        state       <= IDLE;
                        crc_reg     <= INIT;
                        byte_cnt_q  <= '0;
                        crc_valid_q <= 1'b0;
                        s_ready_q   <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    crc_reg   <= INIT;
                    s_ready_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef HDLC_CRC_CHECK_EN
    logic crc_ok_q;

    // Compared pre-XOR: a good frame with its FCS appended leaves the fixed residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_ok_q <= 1'b0;
        end else if (bus.s_abort) begin
            crc_ok_q <= 1'b0;
        end else if (frame_done) begin
            crc_ok_q <= (crc_next == RESIDUE);
        end
    end

    assign bus.crc_ok = crc_ok_q;
`else
    assign bus.crc_ok = 1'b0;
`endif

    assign bus.s_ready   = s_ready_q;
    assign bus.crc_valid = crc_valid_q;
    assign bus.crc_out   = crc_out_q;
    assign bus.byte_cnt  = byte_cnt_q;

endmodule

// File: tb/tb_hdlc_crc_engine.sv
// tb/tb_hdlc_crc_engine.sv - directed self-checking bench for hdlc_crc_engine
module tb_hdlc_crc_engine;

    logic clk;
    logic rst_n;

    int vectors;
    int fails;

    logic [7:0] fb[$];

    hdlc_crc_engine_if #(.DATA_W(16)) b16 ();
    hdlc_crc_engine_if #(.DATA_W(8))  b8  ();
    hdlc_crc_engine_if #(.DATA_W(32)) b32 ();

    hdlc_crc_engine #(.DATA_W(16), .FINAL_XOR(16'h0000)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    hdlc_crc_engine #(.DATA_W(8), .FINAL_XOR(16'hFFFF)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    hdlc_crc_engine #(.DATA_W(32), .FINAL_XOR(16'hFFFF)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b32)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        case (w)
            8:       return b8.s_ready;
            16:      return b16.s_ready;
            default: return b32.s_ready;
        endcase
    endfunction

    function automatic logic vld(input int w);
        case (w)
            8:       return b8.crc_valid;
            16:      return b16.crc_valid;
            default: return b32.crc_valid;
        endcase
    endfunction

    function automatic logic [15:0] crc_of(input int w);
        case (w)
            8:       return b8.crc_out;
            16:      return b16.crc_out;
            default: return b32.crc_out;
        endcase
    endfunction

    function automatic logic [15:0] cnt_of(input int w);
        case (w)
            8:       return b8.byte_cnt;
            16:      return b16.byte_cnt;
            default: return b32.byte_cnt;
        endcase
    endfunction

    function automatic logic ok_of(input int w);
        case (w)
            8:       return b8.crc_ok;
            16:      return b16.crc_ok;
            default: return b32.crc_ok;
        endcase
    endfunction

    task automatic set_beat(input int w, input logic v, input logic [31:0] d,
                            input logic [3:0] k, input logic l, input logic ab);
        case (w)
            8: begin
                b8.s_valid = v; b8.s_data = d[7:0]; b8.s_keep = k[0:0];
                b8.s_last = l; b8.s_abort = ab;
            end
            16: begin
                b16.s_valid = v; b16.s_data = d[15:0]; b16.s_keep = k[1:0];
                b16.s_last = l; b16.s_abort = ab;
            end
            default: begin
                b32.s_valid = v; b32.s_data = d; b32.s_keep = k;
                b32.s_last = l; b32.s_abort = ab;
            end
        endcase
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is taken.
    task automatic drive_beat(input int w, input logic [31:0] d, input logic [3:0] k,
                              input logic l, input logic ab);
        int n;
        set_beat(w, 1'b1, d, k, l, ab);
        n = 0;
        while (!rdy(w) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) begin
            vectors++;
            fails++;
            $display("FAIL ready_timeout: observed s_ready 0 for %0d cycles, required 1", n);
        end
        @(posedge clk); #1;
        set_beat(w, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int w, input bit abort_last, input bit empty_last);
        int nb;
        int i;
        logic [31:0] d;
        logic [3:0]  k;
        logic        lst;
        nb = w / 8;
        i  = 0;
        while (i < fb.size()) begin
            d = '0;
            k = '0;
            for (int j = 0; j < nb; j++) begin
                if (i + j < fb.size()) begin
                    d[8*j +: 8] = fb[i+j];
                    k[j]        = 1'b1;
                end
            end
            i  += nb;
            lst = (i >= fb.size()) && !empty_last;
            drive_beat(w, d, k, lst, abort_last && lst);
        end
        if (empty_last) drive_beat(w, 32'h0, 4'h0, 1'b1, abort_last);
    endtask

    // Expects the result visible right after the last-beat edge and gone one
    // edge later (crc_ready held high).
    task automatic result_check(input int w, input string tag,
                                input logic [15:0] exp_crc, input logic [15:0] exp_cnt);
        check({tag, "_valid"}, 32'(vld(w)), 32'd1);
        check({tag, "_crc"},   32'(crc_of(w)), 32'(exp_crc));
        check({tag, "_cnt"},   32'(cnt_of(w)), 32'(exp_cnt));
        @(posedge clk); #1;
        check({tag, "_valid_clr"}, 32'(vld(w)), 32'd0);
        check({tag, "_ready_back"}, 32'(rdy(w)), 32'd1);
        check({tag, "_cnt_clr"}, 32'(cnt_of(w)), 32'd0);
    endtask

    task automatic load_golden();
        fb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    endtask

    initial begin
        logic exp_ok;
        vectors = 0;
        fails   = 0;
        rst_n   = 1'b0;
        set_beat(8,  1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        set_beat(16, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        set_beat(32, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0);
        b8.crc_ready  = 1'b1;
        b16.crc_ready = 1'b1;
        b32.crc_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready",   32'(b16.s_ready),   32'd0);
        check("rst_crc_valid", 32'(b16.crc_valid), 32'd0);
        check("rst_crc_out",   32'(b16.crc_out),   32'd0);
        check("rst_byte_cnt",  32'(b16.byte_cnt),  32'd0);
        check("rst_crc_ok",    32'(b16.crc_ok),    32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_s_ready_low", 32'(b16.s_ready), 32'd0);
        @(posedge clk); #1;
        check("rel_s_ready_high", 32'(b16.s_ready), 32'd1);

        // Golden "123456789", width 16, no final XOR
        load_golden();
        send_frame(16, 1'b0, 1'b0);
        result_check(16, "w16_gold", 16'h6F91, 16'd9);

        // Same stream, width 8 and width 32 (with empty last beat), final XOR FFFF
        send_frame(8, 1'b0, 1'b0);
        result_check(8, "w8_gold", 16'h906E, 16'd9);
        send_frame(32, 1'b0, 1'b1);
        result_check(32, "w32_gold_emptylast", 16'h906E, 16'd9);

        // Residue check: frame plus its own FCS, then a corrupted copy
`ifdef HDLC_CRC_CHECK_EN
        exp_ok = 1'b1;
`else
        exp_ok = 1'b0;
`endif
        load_golden();
        fb.push_back(8'h6E);
        fb.push_back(8'h90);
        send_frame(8, 1'b0, 1'b0);
        check("chk_good_ok", 32'(b8.crc_ok), 32'(exp_ok));
        result_check(8, "chk_good", 16'h0F47, 16'd11);
        fb[3] = fb[3] ^ 8'h01;
        send_frame(8, 1'b0, 1'b0);
        check("chk_bad_ok", 32'(b8.crc_ok), 32'd0);
        check("chk_bad_cnt", 32'(b8.byte_cnt), 32'd11);
        @(posedge clk); #1;

        // Back-pressure: result held for 5 cycles
        load_golden();
        b16.crc_ready = 1'b0;
        send_frame(16, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid",   32'(b16.crc_valid), 32'd1);
            check("bp_s_ready", 32'(b16.s_ready),   32'd0);
            check("bp_crc",     32'(b16.crc_out),   32'h6F91);
            @(posedge clk); #1;
        end
        b16.crc_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(b16.crc_valid), 32'd0);
        send_frame(16, 1'b0, 1'b0);
        result_check(16, "bp_next", 16'h6F91, 16'd9);

        // Abort on the last beat: no result, then a clean frame
        send_frame(16, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            check("abort_no_valid", 32'(b16.crc_valid), 32'd0);
            @(posedge clk); #1;
        end
        check("abort_cnt", 32'(b16.byte_cnt), 32'd0);
        send_frame(16, 1'b0, 1'b0);
        result_check(16, "after_abort", 16'h6F91, 16'd9);

        // Asynchronous reset mid-frame
        drive_beat(16, 32'h3231, 4'h3, 1'b0, 1'b0);
        drive_beat(16, 32'h3433, 4'h3, 1'b0, 1'b0);
        check("mid_cnt_before_rst", 32'(b16.byte_cnt), 32'd4);
        rst_n = 1'b0;
        #1;
        check("arst_s_ready",   32'(b16.s_ready),   32'd0);
        check("arst_byte_cnt",  32'(b16.byte_cnt),  32'd0);
        check("arst_crc_out",   32'(b16.crc_out),   32'd0);
        check("arst_crc_valid", 32'(b16.crc_valid), 32'd0);
        check("arst_crc_ok",    32'(b16.crc_ok),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_frame(16, 1'b0, 1'b0);
        result_check(16, "after_rst", 16'h6F91, 16'd9);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/hdlc_crc_engine.md
# hdlc_crc_engine

Parametrised CRC-16/CCITT (x^16+x^12+x^5+1) frame engine for the GBT-SCA HDLC path. It accepts a frame as a stream of DATA_W-bit beats with byte-keep and last markers. It returns the frame FCS through a result handshake, together with the frame byte count and, optionally, a receive-side residue check. It sits between the HDLC framer/deframer and the SCA packet buffers, one instance per e-link direction.

## Interface
- DATA_W, 16: beat width in bits; multiple of 8, range 8..64; NB = DATA_W/8 byte lanes.
- INIT, 16'hFFFF: LFSR value at reset and at every frame start.
- FINAL_XOR, 16'h0000: XOR applied to the register to form crc_out.
- RESIDUE, 16'hF0B8: good-frame register value (pre-XOR) for the check feature.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  beat valid.
- s_ready  out  1  engine accepts a beat when s_valid && s_ready.
- s_data  in  DATA_W  beat data; lane k = bits 8k+7:8k.
- s_keep  in  NB  lane valid mask; contiguous from lane 0.
- s_last  in  1  final beat of frame.
- s_abort  in  1  HDLC abort; discard the current frame.
- crc_valid  out  1  result available.
- crc_ready  in  1  result consumed when crc_valid && crc_ready.
- crc_out  out  16  register ^ FINAL_XOR; transmit lane order is crc_out[7:0] first.
- crc_ok  out  1  register == RESIDUE at frame end (macro-gated).
- byte_cnt  out  16  bytes in frame; saturates at 16'hFFFF.

## Operation
- Algorithm is reflected CRC-16: polynomial 0x8408, right-shifting. Each byte is fed LSB first. Lanes are processed 0..NB-1 within a beat, all in one cycle (unrolled chain).
- Only lanes up to the first zero in s_keep are processed. A last beat with s_keep = 0 adds no bytes and still terminates the frame.
- FSM states:
  - IDLE: register = INIT, byte_cnt = 0. An accepted beat moves to BUSY, or to RESULT if s_last.
  - BUSY: each accepted beat updates the register and byte_cnt. A beat with s_last moves to RESULT.
  - RESULT: crc_valid = 1, s_ready = 0, and outputs are held stable. crc_valid && crc_ready reloads INIT, clears byte_cnt and returns to IDLE.
- s_abort in any state forces IDLE with register = INIT and byte_cnt = 0, and no result is produced.
  - Abort coincident with an accepted beat: the abort wins and the beat is dropped.
  - Abort in RESULT: the pending result is discarded.
- byte_cnt accumulates popcount of processed lanes and saturates at 16'hFFFF; the CRC continues past saturation.
- s_ready = 1 in IDLE and BUSY, 0 in RESULT and during reset.

## Timing
- Reset values: state IDLE, register INIT, crc_valid 0, crc_out 0, crc_ok 0, byte_cnt 0, s_ready 0.
- s_ready rises on the first clk edge after rst_n deasserts.
- Throughput is one beat per cycle. There is exactly one bubble per frame when crc_ready is held high.
- Latency: a last beat accepted at edge N gives crc_valid = 1 after edge N, i.e. visible in cycle N+1. All outputs are registered.
- With crc_ready = 1, RESULT lasts exactly one cycle. The next frame's first beat can be accepted at edge N+2.
- An asynchronous rst_n assertion mid-frame or in RESULT immediately returns all outputs to their reset values.

## Configuration
- HDLC_CRC_CHECK_EN defined: the residue comparator is built. crc_ok updates with crc_valid and is held through RESULT.
- HDLC_CRC_CHECK_EN undefined: the comparator is absent and crc_ok is tied 0. The RESIDUE parameter is ignored.

## Structure
- Package hdlc_crc_pkg holds:
  - CRC_POLY_REFL = 16'h8408
  - default INIT, FINAL_XOR and RESIDUE constants
  - the FSM state typedef (IDLE, BUSY, RESULT)
- Sub-module hdlc_crc_byte_step: combinational 16-bit register + 8-bit byte -> next register. It is instantiated NB times as a chain; each stage bypasses when its keep bit (ANDed with all lower keep bits) is 0.

## Test plan
- DATA_W=16, FINAL_XOR=0: feed ASCII "123456789" as beats 0x3231, 0x3433, 0x3635, 0x3837, then 0x0039 with keep=01 and last. Expect crc_out = 16'h6F91, byte_cnt = 9, crc_valid one cycle after the last beat.
- Same stream with FINAL_XOR=16'hFFFF and DATA_W=8 and DATA_W=32. Expect crc_out = 16'h906E and identical byte_cnt in every width.
- Check feature: "123456789" followed by bytes 0x6E, 0x90, with FINAL_XOR=FFFF. Expect crc_ok = 1, byte_cnt = 11. Flip one data bit and expect crc_ok = 0.
- Back-pressure: hold crc_ready = 0 for 5 cycles. Expect s_ready = 0 and crc_out stable throughout, then an immediate next frame yields the correct CRC (not carried over).
- Abort: assert s_abort together with the last beat of a frame. Expect no crc_valid. The following "123456789" frame gives 16'h6F91.
- Reset: drop rst_n mid-frame. Expect all outputs at reset values and s_ready = 0. After release, the next frame's CRC matches the golden value.
